// File: rtl/bus_fabric_if.sv
// CPU data bus plus the fabric's slave-side strobes, selects and return data.
interface bus_fabric_if #(
  parameter int NSLAVE = 8,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  logic [AW-1:0]             address;
  logic                      read;
  logic                      write;
  logic [DW-1:0]             writedata;
  logic [DW/8-1:0]           byteenable;
  logic [DW-1:0]             readdata;
  logic                      waitrequest;
  logic                      fault;
  logic [AW-1:0]             fault_addr;
  logic                      start;
  logic [NSLAVE-1:0]         chipselect;
  logic [NSLAVE-1:0]         s_read;
  logic [NSLAVE-1:0]         s_write;
  logic [NSLAVE-1:0]         s_ready;
  logic [NSLAVE-1:0][DW-1:0] s_readdata;

  // Fabric view: CPU request and slave responses in, CPU response and slave controls out.
  // writedata/byteenable are shared wires that the slaves sample directly.
  modport slave (
    input  address, read, write, writedata, byteenable, s_ready, s_readdata,
    output readdata, waitrequest, fault, fault_addr, start, chipselect, s_read, s_write
  );

  // CPU/slave-model view: the mirror image.
  modport master (
    output address, read, write, writedata, byteenable, s_ready, s_readdata,
    input  readdata, waitrequest, fault, fault_addr, start, chipselect, s_read, s_write
  );
endinterface

// File: rtl/bus_fabric.sv
// Single-master bus interconnect: base/mask address decode, one-hot chipselect,
// per-slave strobes, readdata mux, fixed wait states or ready handshake with timeout.

// One address window comparator.
module bus_fabric_win #(
  parameter int            AW   = 32,
  parameter logic [AW-1:0] BASE = '0,
  parameter logic [AW-1:0] MASK = '0
) (
  input  logic [AW-1:0] address,
  output logic          hit
);
  assign hit = (address & MASK) == BASE;
endmodule

module bus_fabric #(
  parameter int                  NSLAVE   = 8,
  parameter int                  AW       = 32,
  parameter int                  DW       = 32,
  parameter logic [NSLAVE*AW-1:0] MAP_BASE = '0,
  parameter logic [NSLAVE*AW-1:0] MAP_MASK = '0,
  parameter logic [NSLAVE*4-1:0]  WAIT_CYC = '0,
  parameter int                  TIMEOUT  = 255
) (
  input  logic      clk,
  input  logic      rst_n,
  bus_fabric_if.slave bus
);
  localparam int IW   = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;
  localparam int TMAX = (TIMEOUT > 15) ? TIMEOUT : 15;
  localparam int CW   = $clog2(TMAX) + 1;
  localparam logic [NSLAVE-1:0][3:0] WTAB = WAIT_CYC;

  typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_t;

  // Access latched at decode time.
  typedef struct packed {
    logic [IW-1:0] idx;
    logic          wr;
  } acc_t;

  state_t            state;
  acc_t              acc;
  logic [CW-1:0]     cnt;
  logic              fixed_q;
  logic [NSLAVE-1:0] cs_q;
  logic              first_q;
  logic [AW-1:0]     fault_addr_q;

  logic [NSLAVE-1:0] hit;
  logic              hit_any;
  logic [IW-1:0]     hit_idx;
  logic [3:0]        wait_n;
  logic              req, in_acc, tmo, fin, done, strobe_ok;

  for (genvar g = 0; g < NSLAVE; g++) begin : g_win
    bus_fabric_win #(
      .AW   (AW),
      .BASE (MAP_BASE[g*AW +: AW]),
      .MASK (MAP_MASK[g*AW +: AW])
    ) u_win (
      .address (bus.address),
      .hit     (hit[g])
    );
  end

  // Priority decode: scanning downward leaves the lowest hitting index.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if (hit[i]) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign wait_n = WTAB[hit_idx];
  assign req    = bus.read | bus.write;
  assign in_acc = (state == ACCESS);
  // Ready-mode counter exhausted: this ACCESS cycle is the timeout completion.
  assign tmo    = in_acc & ~fixed_q & (cnt == '0);
  assign fin    = in_acc & (fixed_q ? (cnt == CW'(1)) : (tmo | bus.s_ready[acc.idx]));
  assign done   = (state == ERR) | fin;
  assign strobe_ok = in_acc & req;

  assign bus.waitrequest = req & ~done;
  assign bus.fault       = (state == ERR) | (tmo & req);
  assign bus.readdata    = (fin & req & ~tmo & ~acc.wr) ? bus.s_readdata[acc.idx] : '0;
  assign bus.s_read      = cs_q & {NSLAVE{strobe_ok & ~acc.wr}};
  assign bus.s_write     = cs_q & {NSLAVE{strobe_ok & acc.wr}};
  // A dropped request deselects in the same cycle rather than waiting for the register.
  assign bus.chipselect  = cs_q & {NSLAVE{req}};
  assign bus.start       = first_q;
  assign bus.fault_addr  = fault_addr_q;

  // Access sequencer: decode, wait/handshake/timeout, error completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      fixed_q      <= 1'b0;
      cs_q         <= '0;
      first_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      first_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (hit_any) begin
              acc.idx <= hit_idx;
              acc.wr  <= bus.write;
              cs_q    <= NSLAVE'(1) << hit_idx;
              first_q <= 1'b1;
              state   <= ACCESS;
              if (wait_n != 4'd0) begin
                fixed_q <= 1'b1;
                cnt     <= CW'(wait_n);
              end else begin
                fixed_q <= 1'b0;
                cnt     <= CW'(TIMEOUT);
              end
            end else begin
              state <= ERR;
            end
          end
        end
        ACCESS: begin
          if (!req || fin) begin
            state <= IDLE;
            cs_q  <= '0;
            cnt   <= '0;
            if (req && tmo) fault_addr_q <= bus.address;
          end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end
        end
        ERR: begin
          fault_addr_q <= bus.address;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
